// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register of the five-stage MIPS32 core.
// Registers the EX result bundle for the MEM stage, honours the global
// stall/flush controls and loops the two-cycle MADD/MSUB partial product
// (hilo temp plus cycle count) back to EX while EX is stalled.
module ex_mem_reg #(
    parameter int STALL_W = 6,
    parameter int EX_BIT  = 3,
    parameter int MEM_BIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [4:0]         ex_wd,
    input  logic               ex_wreg,
    input  logic [31:0]        ex_wdata,
    input  logic [7:0]         ex_aluop,
    input  logic [31:0]        ex_mem_addr,
    input  logic [31:0]        ex_reg2,
    input  logic               ex_whilo,
    input  logic [31:0]        ex_hi,
    input  logic [31:0]        ex_lo,
    input  logic [63:0]        hilo_i,
    input  logic [1:0]         cnt_i,
    output logic [4:0]         mem_wd,
    output logic               mem_wreg,
    output logic [31:0]        mem_wdata,
    output logic [7:0]         mem_aluop,
    output logic [31:0]        mem_mem_addr,
    output logic [31:0]        mem_reg2,
    output logic               mem_whilo,
    output logic [31:0]        mem_hi,
    output logic [31:0]        mem_lo,
    output logic [63:0]        hilo_o,
    output logic [1:0]         cnt_o
);

    // Pipeline state presented to MEM
    logic [4:0]  r_wd;
    logic        r_wreg;
    logic [31:0] r_wdata;
    logic [7:0]  r_aluop;
    logic [31:0] r_mem_addr;
    logic [31:0] r_reg2;
    logic        r_whilo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Multiply-accumulate temp returned to EX
    logic [63:0] r_hilo;
    logic [1:0]  r_cnt;

    // Stall decode; only the EX and MEM bits matter here
    logic w_ex_stall;
    logic w_mem_stall;
    logic w_hold;
    logic w_bubble;
    logic w_unused_stall;

    assign w_ex_stall     = stall[EX_BIT];
    assign w_mem_stall    = stall[MEM_BIT];
    assign w_hold         = w_ex_stall & w_mem_stall;
    // An EX stall without a MEM stall inserts a NOP into MEM.
    assign w_bubble       = w_ex_stall & ~w_mem_stall;
    // Remaining stall bits belong to other stages and are deliberately ignored.
    assign w_unused_stall = ^stall;

    // Pipeline register update: reset > flush > hold > bubble > advance
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wd       <= 5'd0;
            r_wreg     <= 1'b0;
            r_wdata    <= 32'd0;
            r_aluop    <= 8'd0;
            r_mem_addr <= 32'd0;
            r_reg2     <= 32'd0;
            r_whilo    <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_hilo     <= 64'd0;
            r_cnt      <= 2'd0;
        end else if (w_hold) begin
            // Everything, including the MADD temp, keeps its value.
            r_wd       <= r_wd;
            r_wreg     <= r_wreg;
            r_wdata    <= r_wdata;
            r_aluop    <= r_aluop;
            r_mem_addr <= r_mem_addr;
            r_reg2     <= r_reg2;
            r_whilo    <= r_whilo;
            r_hi       <= r_hi;
            r_lo       <= r_lo;
            r_hilo     <= r_hilo;
            r_cnt      <= r_cnt;
        end else if (w_bubble) begin
            // NOP into MEM; EX still owns the instruction, so keep its
            // first-cycle partial product for the second MADD/MSUB cycle.
            r_wd       <= 5'd0;
            r_wreg     <= 1'b0;
            r_wdata    <= 32'd0;
            r_aluop    <= 8'd0;
            r_mem_addr <= 32'd0;
            r_reg2     <= 32'd0;
            r_whilo    <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_hilo     <= hilo_i;
            r_cnt      <= cnt_i;
        end else begin
            // Advance (also taken for the unreachable EX-run/MEM-stall case);
            // the instruction has left EX so its temp is cleared.
            r_wd       <= ex_wd;
            r_wreg     <= ex_wreg;
            r_wdata    <= ex_wdata;
            r_aluop    <= ex_aluop;
            r_mem_addr <= ex_mem_addr;
            r_reg2     <= ex_reg2;
            r_whilo    <= ex_whilo;
            r_hi       <= ex_hi;
            r_lo       <= ex_lo;
            r_hilo     <= 64'd0;
            r_cnt      <= 2'd0;
        end
    end

    assign mem_wd       = r_wd;
    assign mem_wreg     = r_wreg;
    assign mem_wdata    = r_wdata;
    assign mem_aluop    = r_aluop;
    assign mem_mem_addr = r_mem_addr;
    assign mem_reg2     = r_reg2;
    assign mem_whilo    = r_whilo;
    assign mem_hi       = r_hi;
    assign mem_lo       = r_lo;
    assign hilo_o       = r_hilo;
    assign cnt_o        = r_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed-vector bench for the EX/MEM pipeline register.
module tb_ex_mem_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int checks_cnt;
    int failures_cnt;

    localparam logic [7:0] ALUOP_SW = 8'hEB;

    ex_mem_reg #(.STALL_W(6), .EX_BIT(3), .MEM_BIT(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl stalls contiguously, so EX running while MEM stalls never happens
    always @(posedge clk) begin
        if (rst) begin
            assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
                else $error("illegal stall pattern %b", stall);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".wd"},       64'(mem_wd),       64'd0);
        check_val({tag, ".wreg"},     64'(mem_wreg),     64'd0);
        check_val({tag, ".wdata"},    64'(mem_wdata),    64'd0);
        check_val({tag, ".aluop"},    64'(mem_aluop),    64'd0);
        check_val({tag, ".mem_addr"}, 64'(mem_mem_addr), 64'd0);
        check_val({tag, ".reg2"},     64'(mem_reg2),     64'd0);
        check_val({tag, ".whilo"},    64'(mem_whilo),    64'd0);
        check_val({tag, ".hi"},       64'(mem_hi),       64'd0);
        check_val({tag, ".lo"},       64'(mem_lo),       64'd0);
        check_val({tag, ".hilo"},     hilo_o,            64'd0);
        check_val({tag, ".cnt"},      64'(cnt_o),        64'd0);
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        ex_wd    = wd;
        ex_wreg  = wreg;
        ex_wdata = wdata;
    endtask

    // One clock edge, then settle away from the edge before sampling
    task automatic tick(input string name);
        @(posedge clk);
        #1;
        $display("txn %-12s stall=%b flush=%b rst=%b wd=%0d wdata=0x%08h hilo=0x%016h cnt=%0d",
                 name, stall, flush, rst, mem_wd, mem_wdata, hilo_o, cnt_o);
    endtask

    initial begin
        checks_cnt   = 0;
        failures_cnt = 0;

        // Reset with every input driven to all-ones
        rst = 1'b0; flush = 1'b1; stall = 6'h3F;
        ex_wd = 5'h1F; ex_wreg = 1'b1; ex_wdata = 32'hFFFFFFFF; ex_aluop = 8'hFF;
        ex_mem_addr = 32'hFFFFFFFF; ex_reg2 = 32'hFFFFFFFF; ex_whilo = 1'b1;
        ex_hi = 32'hFFFFFFFF; ex_lo = 32'hFFFFFFFF; hilo_i = 64'hFFFFFFFF_FFFFFFFF; cnt_i = 2'd3;
        #2;
        tick("reset1");
        check_all_zero("rst1");
        tick("reset2");
        check_all_zero("rst2");

        rst = 1'b1; flush = 1'b0; stall = 6'b0;
        tick("post_rst");
        check_val("post_rst.wdata", 64'(mem_wdata), 64'hFFFFFFFF);
        check_val("post_rst.wd",    64'(mem_wd),    64'h1F);
        check_val("post_rst.hi",    64'(mem_hi),    64'hFFFFFFFF);
        check_val("post_rst.hilo",  hilo_o,         64'd0);
        check_val("post_rst.cnt",   64'(cnt_o),     64'd0);

        // Advance stream
        ex_aluop = 8'h21; ex_whilo = 1'b0; hilo_i = 64'd0; cnt_i = 2'd0;
        set_ex(5'd1, 1'b1, 32'h11);
        tick("adv1");
        check_val("adv1.wd", 64'(mem_wd), 64'd1);
        check_val("adv1.wdata", 64'(mem_wdata), 64'h11);
        set_ex(5'd2, 1'b1, 32'h22);
        tick("adv2");
        check_val("adv2.wd", 64'(mem_wd), 64'd2);
        check_val("adv2.wdata", 64'(mem_wdata), 64'h22);
        set_ex(5'd3, 1'b1, 32'h33);
        tick("adv3");
        check_val("adv3.wd", 64'(mem_wd), 64'd3);
        check_val("adv3.wdata", 64'(mem_wdata), 64'h33);
        check_val("adv3.wreg", 64'(mem_wreg), 64'd1);

        // Upper stall bits (WB) alone do not stall this register
        stall = 6'b100111;
        set_ex(5'd4, 1'b1, 32'h44);
        tick("ignore_bits");
        check_val("ign.wdata", 64'(mem_wdata), 64'h44);

        // Bubble: NOP to MEM, MADD temp forwarded back
        stall = 6'b001111;
        set_ex(5'd5, 1'b1, 32'h55);
        ex_whilo = 1'b1; hilo_i = 64'h00000001_FFFFFFFE; cnt_i = 2'd1;
        tick("bubble");
        check_val("bub.wreg",  64'(mem_wreg),  64'd0);
        check_val("bub.wd",    64'(mem_wd),    64'd0);
        check_val("bub.wdata", 64'(mem_wdata), 64'd0);
        check_val("bub.whilo", 64'(mem_whilo), 64'd0);
        check_val("bub.hilo",  hilo_o, 64'h00000001_FFFFFFFE);
        check_val("bub.cnt",   64'(cnt_o), 64'd1);

        stall = 6'b0; hilo_i = 64'h1234; cnt_i = 2'd2;
        tick("bub_release");
        check_val("rel.hilo",  hilo_o, 64'd0);
        check_val("rel.cnt",   64'(cnt_o), 64'd0);
        check_val("rel.wd",    64'(mem_wd), 64'd5);
        check_val("rel.wreg",  64'(mem_wreg), 64'd1);
        check_val("rel.wdata", 64'(mem_wdata), 64'h55);
        check_val("rel.whilo", 64'(mem_whilo), 64'd1);

        // Hold: load 0xDEADBEEF, then stall EX and MEM while inputs change
        ex_whilo = 1'b0; hilo_i = 64'd0; cnt_i = 2'd0;
        set_ex(5'd6, 1'b1, 32'hDEADBEEF);
        tick("load_dead");
        check_val("load.wdata", 64'(mem_wdata), 64'hDEADBEEF);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(7 + i), 1'b0, 32'hA0 + 32'(i));
            hilo_i = 64'hCAFE_0000 + 64'(i); cnt_i = 2'd1;
            tick("hold");
            check_val("hold.wdata", 64'(mem_wdata), 64'hDEADBEEF);
            check_val("hold.wd",    64'(mem_wd),    64'd6);
            check_val("hold.hilo",  hilo_o,         64'd0);
            check_val("hold.cnt",   64'(cnt_o),     64'd0);
        end

        // Flush wins over hold with nonzero held mem state
        flush = 1'b1;
        tick("flush_hold");
        check_all_zero("fl_hold");
        flush = 1'b0;

        // Capture a temp with a bubble, hold it, then flush over a bubble
        stall = 6'b001111; hilo_i = 64'h89AB_CDEF_0123_4567; cnt_i = 2'd2;
        tick("bubble2");
        check_val("bub2.hilo", hilo_o, 64'h89AB_CDEF_0123_4567);
        stall = 6'b011111; hilo_i = 64'h5555; cnt_i = 2'd3;
        tick("hold2");
        check_val("hold2.hilo", hilo_o, 64'h89AB_CDEF_0123_4567);
        check_val("hold2.cnt",  64'(cnt_o), 64'd2);
        stall = 6'b001111; flush = 1'b1;
        tick("flush_bub");
        check_all_zero("fl_bub");
        flush = 1'b0; stall = 6'b0;

        // Reset wins over flush and bubble
        set_ex(5'd9, 1'b1, 32'h99);
        tick("load_99");
        check_val("load99.wdata", 64'(mem_wdata), 64'h99);
        rst = 1'b0; flush = 1'b1; stall = 6'b001111;
        hilo_i = 64'h7777; cnt_i = 2'd1;
        tick("rst_prio");
        check_all_zero("rst_prio");

        // Store passes through unchanged after reset
        rst = 1'b1; flush = 1'b0; stall = 6'b0; hilo_i = 64'd0; cnt_i = 2'd0;
        set_ex(5'd0, 1'b0, 32'h80001000);
        ex_aluop = ALUOP_SW; ex_mem_addr = 32'h80001000; ex_reg2 = 32'h12345678;
        ex_hi = 32'h0BADF00D; ex_lo = 32'h600DCAFE;
        tick("store");
        check_val("st.aluop", 64'(mem_aluop),    64'(ALUOP_SW));
        check_val("st.addr",  64'(mem_mem_addr), 64'h80001000);
        check_val("st.reg2",  64'(mem_reg2),     64'h12345678);
        check_val("st.wreg",  64'(mem_wreg),     64'd0);
        check_val("st.hi",    64'(mem_hi),       64'h0BADF00D);
        check_val("st.lo",    64'(mem_lo),       64'h600DCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the five-stage MIPS32 core.
- Captures the EX result fields each cycle: destination, write enable, ALU result, aluop, load/store address, store data and HI/LO writeback.
- Presents those fields to MEM one cycle later.
- Implements global stall and flush control.
- Carries the two-cycle MADD/MADDU/MSUB/MSUBU partial product (hilo temp plus cycle count) back to EX while EX is stalled.

Parameters:
- STALL_W, 6, width of the stall vector (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB).
- EX_BIT, 3, stall bit index for the EX stage.
- MEM_BIT, 4, stall bit index for the MEM stage.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the next rising edge of clk).
- stall  in  STALL_W  per-stage stall from the ctrl block.
- flush  in  1  exception flush; clears the register.
- ex_wd  in  5  destination GPR address.
- ex_wreg  in  1  GPR write enable.
- ex_wdata  in  32  ALU result.
- ex_aluop  in  8  operation code (load/store decode in MEM).
- ex_mem_addr  in  32  effective load/store address.
- ex_reg2  in  32  store data / LWL-LWR merge operand.
- ex_whilo  in  1  HI/LO write enable.
- ex_hi  in  32  HI write value.
- ex_lo  in  32  LO write value.
- hilo_i  in  64  MADD/MSUB first-cycle partial result from EX.
- cnt_i  in  2  MADD/MSUB cycle counter from EX.
- mem_wd  out  5  registered ex_wd.
- mem_wreg  out  1  registered ex_wreg.
- mem_wdata  out  32  registered ex_wdata.
- mem_aluop  out  8  registered ex_aluop.
- mem_mem_addr  out  32  registered ex_mem_addr.
- mem_reg2  out  32  registered ex_reg2.
- mem_whilo  out  1  registered ex_whilo.
- mem_hi  out  32  registered ex_hi.
- mem_lo  out  32  registered ex_lo.
- hilo_o  out  64  partial result returned to EX.
- cnt_o  out  2  cycle counter returned to EX.

Behaviour:
- Reset (rst=0 at a rising edge): every output is 0, including hilo_o and cnt_o. Reset wins over flush and stall.
- Flush (rst=1, flush=1): every output is 0 on the next edge, including hilo_o and cnt_o. Flush wins over stall, so an in-flight MADD partial is discarded.
- Bubble (stall[EX_BIT]=1, stall[MEM_BIT]=0):
  - All mem_* outputs go to 0, a NOP into MEM with mem_wreg=0 and mem_whilo=0.
  - hilo_o<=hilo_i and cnt_o<=cnt_i, so EX completes the multiply-accumulate in the next cycle.
- Hold (stall[EX_BIT]=1, stall[MEM_BIT]=1): all outputs, including hilo_o and cnt_o, keep their current values.
- Advance (stall[EX_BIT]=0):
  - Every mem_* output takes the matching ex_* input.
  - hilo_o<=0 and cnt_o<=0, clearing the temp once the instruction leaves EX.
- stall[EX_BIT]=0 with stall[MEM_BIT]=1 is illegal (ctrl stalls contiguously from the PC). The block treats it as Advance, and the bench asserts it never occurs.
- Latency is exactly one cycle from ex_* to mem_*. There is no combinational path from input to output.
- Stall bits other than EX_BIT and MEM_BIT are ignored.
- Reset mid-MADD clears cnt_o and hilo_o. EX must treat cnt_i=0 as "first cycle".
- Widths are fixed: no truncation or extension inside the block.

Test Plan:
- rst=0 for 2 cycles with all inputs 0xFFFFFFFF/1 -> every output 0; after rst=1 and stall=0, the next edge passes ex_wdata=0xFFFFFFFF to mem_wdata.
- Advance stream: three back-to-back instructions (wd=1,2,3; wdata=0x11,0x22,0x33; wreg=1) -> mem_wd/mem_wdata follow one cycle later, values 1/0x11, 2/0x22, 3/0x33.
- Bubble: stall=6'b001111, ex_wreg=1, ex_wd=5, hilo_i=0x00000001_FFFFFFFE, cnt_i=1 -> mem_wreg=0, mem_wd=0, hilo_o=0x00000001_FFFFFFFE, cnt_o=1. Next cycle stall=0 -> hilo_o=0, cnt_o=0, mem_* carry the EX values.
- Hold: load mem_wdata=0xDEADBEEF, then stall=6'b011111 for 3 cycles while ex_* change -> mem_wdata stays 0xDEADBEEF and hilo_o/cnt_o stay unchanged.
- Flush priority: flush=1 with stall=6'b011111 and nonzero held state -> all outputs 0 after one edge.
- Reset priority: rst=0 together with flush=1 and stall=6'b001111 -> all outputs 0. A store (aluop SW, mem_addr=0x80001000, reg2=0x12345678) presented after reset appears unchanged on mem_aluop/mem_mem_addr/mem_reg2 one edge later.
